// File: rtl/fetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, buffers up to DEPTH {pc, instr}
// pairs from a combinational instruction memory and flushes on a taken branch.
module fetch_queue #(
  parameter int unsigned          AW       = 32,
  parameter int unsigned          IW       = 32,
  parameter int unsigned          DEPTH    = 4,
  parameter logic        [AW-1:0] RESET_PC = '0
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  output logic [AW-1:0]                im_addr_o,
  input  logic [IW-1:0]                im_data_i,
  input  logic                         fetch_en_i,
  input  logic                         redirect_i,
  input  logic [AW-1:0]                redirect_pc_i,
  output logic                         out_valid_o,
  output logic [AW-1:0]                out_pc_o,
  output logic [IW-1:0]                out_instr_o,
  input  logic                         out_ready_i,
  output logic [$clog2(DEPTH):0]       count_o,
  output logic                         full_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [IW-1:0] instr;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [CW-1:0] cnt_q,  cnt_d;
  logic [AW-1:0] fpc_q,  fpc_d;

  logic not_empty;
  logic pop;
  logic push;

  // A redirect masks the head so the branch shadow is never consumed.
  assign not_empty = (cnt_q != '0);
  assign pop       = not_empty & ~redirect_i & out_ready_i;
  assign push      = fetch_en_i & ~redirect_i & ((cnt_q != DEPTH_C) | pop);

  // NOTE: next-state logic is purely combinational; every _d gets a default
  // first so no path through the block can infer a latch.
  always_comb begin
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    cnt_d  = cnt_q;
    fpc_d  = fpc_q;

    if (redirect_i) begin
      rptr_d = wptr_q;
      cnt_d  = '0;
      fpc_d  = redirect_pc_i;
    end else begin
      if (pop) begin
        rptr_d = rptr_q + PW'(1);
      end
      if (push) begin
        wptr_d = wptr_q + PW'(1);
        fpc_d  = fpc_q + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments only, so every flop
  // samples the values from before the edge regardless of block ordering.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
      fpc_q  <= RESET_PC;
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
      fpc_q  <= fpc_d;
    end
  end

  // NOTE: the storage array is reset on purpose: the head is read straight from
  // it, and the outputs must be defined (zero) right after reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wptr_q] <= '{pc: fpc_q, instr: im_data_i};
    end
  end

  assign im_addr_o   = fpc_q;
  assign out_valid_o = not_empty & ~redirect_i;
  assign out_pc_o    = mem_q[rptr_q].pc;
  assign out_instr_o = mem_q[rptr_q].instr;
  assign count_o     = cnt_q;
  assign full_o      = (cnt_q == DEPTH_C);

endmodule
